jar_sram_ctrl: RTL and testbench
================================

JAR_SRAM_CTRL -- requirements
Module: jar_sram_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, word width in bits; multiple of 4, minimum 4.
REQ-002 SHALL have parameter DEPTH, default 16, number of words; power of 2, minimum 2.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), address width; NA = ceil(AW/4) address nibbles, NW = DW/4 nibbles per word.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cs  input  1  transaction select; high frames one transaction.
REQ-007 SHALL have port stb  input  1  nibble strobe; one nibble transferred per clk with stb high.
REQ-008 SHALL have port nib_in  input  4  header, address or write-data nibble.
REQ-009 SHALL have port nib_out  output  4  read-data nibble.
REQ-010 SHALL have port out_vld  output  1  nib_out valid, one-cycle pulse.
REQ-011 SHALL have port busy  output  1  high while stb is ignored (fetch or clear).
REQ-012 SHALL have port err  output  1  illegal-header flag.

Function
REQ-013 SHALL hold DEPTH x DW memory; contents not reset.
REQ-014 SHALL use FSM states IDLE, HDR, ADDR, WR, RD_FETCH, RD, CLR, ERR.
REQ-015 SHALL go IDLE->HDR when cs high; in any state except CLR, cs low SHALL force IDLE on the next edge, with any stb in that cycle ignored.
REQ-016 SHALL decode the first stb nibble in HDR: 0x1 write, 0x2 read, 0x3 clear (REQ-029), else ERR.
REQ-017 SHALL collect NA address nibbles in ADDR, least significant first; bits above AW discarded.
REQ-018 SHALL in WR shift each nibble in from the top, LSN first; on the NWth nibble write the word at the current address on that edge, increment the address, and reset the nibble count.
REQ-019 SHALL discard a partially assembled word when cs falls; memory unchanged.
REQ-020 SHALL enter RD_FETCH after the last address nibble of a read: one cycle, busy=1, word loaded into the output shift register, then RD.
REQ-021 SHALL in RD, per stb, drive the next nibble (LSN first) on nib_out with out_vld=1 in the following cycle; after the NWth nibble, increment the address and return to RD_FETCH.
REQ-022 SHALL wrap address increments from DEPTH-1 to 0 in both write and read bursts.
REQ-023 SHALL ignore stb while busy=1; no nibble is consumed.
REQ-024 SHALL hold err=1 in ERR, ignore all stb and block writes until cs is low, then clear err and go IDLE.
REQ-025 SHALL hold nib_out at its last value when out_vld=0.

Reset
REQ-026 SHALL on rst_n low immediately force state IDLE, nib_out=0, out_vld=0, busy=0, err=0, and clear the address, nibble count and shift registers.
REQ-027 SHALL abort any write, read or clear in progress on reset; words already written, or cleared, remain.
REQ-028 SHALL leave reset synchronously to clk; the first active edge after rst_n rises is a normal cycle.

Configuration
REQ-029 SHALL, with macro JAR_SRAM_CLEAR_EN defined, treat header 0x3 as clear: state CLR, busy=1 for exactly DEPTH cycles, one word zeroed per cycle from address 0 upward. The clear SHALL run to completion even if cs falls, then go IDLE if cs is low, otherwise HDR.
REQ-030 SHALL, without JAR_SRAM_CLEAR_EN, treat header 0x3 as illegal (ERR) and contain no clear logic.

Verification (DW=8, DEPTH=16)
REQ-031 SHALL check reset: rst_n low mid-burst -> nib_out=0, out_vld=0, busy=0, err=0 within the same cycle; the next cs starts in HDR.
REQ-032 SHALL check write/read: cs, stb nibbles 0x1,0x3,0x5,0xA; drop cs; cs, 0x2,0x3; after busy falls, 2 stb -> nib_out 0x5 then 0xA with out_vld pulses.
REQ-033 SHALL check wrap: write burst at address 15 of 0x11,0x22 -> read address 0 gives 0x22; a read burst from 15 gives nibbles 1,1,2,2.
REQ-034 SHALL check abort: write header 0x1, address 0x4, one nibble 0x7, cs low -> address 4 keeps its prior value 0x5A.
REQ-035 SHALL check illegal header: nibble 0x4 -> err=1; subsequent nibbles 0x1,0x0,0xF,0xF cause no write; cs low -> err=0.
REQ-036 SHALL check clear: header 0x3 with the macro -> busy high for 16 cycles and every address reads 0x00; without the macro -> err=1.

Source files
------------

// File: rtl/jar_sram_ctrl.sv
// ----------------------------------------------------------------------------
// jar_sram_ctrl : nibble-serial SRAM controller; optional clear via JAR_SRAM_CLEAR_EN
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jar_sram_ctrl #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       stb,
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out,
  output logic       out_vld,
  output logic       busy,
  output logic       err
);

  localparam int NA   = (AW + 3) / 4;
  localparam int NW   = DW / 4;
  localparam int MAXN = (NA > NW) ? NA : NW;
  localparam int CW   = $clog2(MAXN) + 1;
  localparam logic [CW-1:0] NA_LAST = CW'(NA - 1);
  localparam logic [CW-1:0] NW_LAST = CW'(NW - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HDR      = 3'd1;
  localparam logic [2:0] ADDR     = 3'd2;
  localparam logic [2:0] WR       = 3'd3;
  localparam logic [2:0] RD_FETCH = 3'd4;
  localparam logic [2:0] RD       = 3'd5;
  localparam logic [2:0] CLR      = 3'd6;
  localparam logic [2:0] ERR      = 3'd7;

  logic [DW-1:0] mem [DEPTH];

  logic [2:0]    state_q,   state_d;
  logic          op_rd_q,   op_rd_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [DW-1:0] wr_sh_q,   wr_sh_d;
  logic [DW-1:0] rd_sh_q,   rd_sh_d;
  logic [3:0]    nib_out_q, nib_out_d;
  logic          out_vld_q, out_vld_d;

  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [4*NA-1:0] addr_ext;
  logic [DW-1:0] nib_top;

  always_comb begin
    state_d   = state_q;
    op_rd_d   = op_rd_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_sh_d   = wr_sh_q;
    rd_sh_d   = rd_sh_q;
    nib_out_d = nib_out_q;
    out_vld_d = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    addr_ext  = '0;
    addr_ext[AW-1:0] = addr_q;
    nib_top   = '0;
    nib_top[DW-1 -: 4] = nib_in;

    case (state_q)
      IDLE: if (cs) state_d = HDR;
      HDR: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (stb) begin
          cnt_d  = '0;
          addr_d = '0;
          case (nib_in)
            4'h1: begin state_d = ADDR; op_rd_d = 1'b0; end
            4'h2: begin state_d = ADDR; op_rd_d = 1'b1; end
`ifdef JAR_SRAM_CLEAR_EN
            4'h3: state_d = CLR;
`endif
            default: state_d = ERR;
          endcase
        end
      end
      ADDR: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (stb) begin
          // Address nibbles arrive LSN first; anything above AW is dropped.
          for (int i = 0; i < NA; i++) begin
            if (cnt_q == i[CW-1:0]) addr_ext[i*4 +: 4] = nib_in;
          end
          addr_d = addr_ext[AW-1:0];
          if (cnt_q == NA_LAST) begin
            cnt_d   = '0;
            state_d = op_rd_q ? RD_FETCH : WR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (stb) begin
          wr_sh_d = (wr_sh_q >> 4) | nib_top;
          if (cnt_q == NW_LAST) begin
            mem_we    = 1'b1;
            mem_wdata = wr_sh_d;
            addr_d    = addr_q + 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RD_FETCH: begin
        if (!cs) begin
          state_d = IDLE;
        end else begin
          rd_sh_d = mem[addr_q];
          cnt_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (stb) begin
          nib_out_d = rd_sh_q[3:0];
          out_vld_d = 1'b1;
          rd_sh_d   = rd_sh_q >> 4;
          if (cnt_q == NW_LAST) begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = '0;
            state_d = RD_FETCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef JAR_SRAM_CLEAR_EN
      CLR: begin
        // Runs to completion regardless of cs.
        mem_we = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == AW'(DEPTH - 1)) state_d = cs ? HDR : IDLE;
      end
`else
      CLR: state_d = IDLE;
`endif
      ERR: if (!cs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_rd_q   <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_sh_q   <= '0;
      rd_sh_q   <= '0;
      nib_out_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_rd_q   <= op_rd_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_sh_q   <= wr_sh_d;
      rd_sh_q   <= rd_sh_d;
      nib_out_q <= nib_out_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

  assign nib_out = nib_out_q;
  assign out_vld = out_vld_q;
  assign err     = (state_q == ERR);
`ifdef JAR_SRAM_CLEAR_EN
  assign busy    = (state_q == RD_FETCH) || (state_q == CLR);
`else
  assign busy    = (state_q == RD_FETCH);
`endif

endmodule

`default_nettype wire

// File: tb/tb_jar_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_jar_sram_ctrl : scoreboard bench for jar_sram_ctrl (DW=8, DEPTH=16)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_jar_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       stb;
  logic [3:0] nib_in;
  logic [3:0] nib_out;
  logic       out_vld;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  jar_sram_ctrl #(.DW(8), .DEPTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .stb     (stb),
    .nib_in  (nib_in),
    .nib_out (nib_out),
    .out_vld (out_vld),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out_vld pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_nibble: got %0h expected none", nib_out);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (nib_out !== e) begin
          errors++;
          $display("FAIL read_nibble: got %0h expected %0h", nib_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    cs = 1'b1; stb = 1'b0;
    tick();
  endtask

  task automatic stop();
    cs = 1'b0; stb = 1'b0;
    tick();
  endtask

  task automatic nib(input logic [3:0] n);
    nib_in = n; stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] w);
    start(); nib(4'h1); nib(a); nib(w[3:0]); nib(w[7:4]); stop();
  endtask

  task automatic read_word(input logic [3:0] a, input logic [7:0] w);
    start(); nib(4'h2); nib(a);
    wait_ready();
    exp_q.push_back(w[3:0]); nib(4'h0);
    exp_q.push_back(w[7:4]); nib(4'h0);
    stop(); tick();
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; stb = 1'b0; nib_in = 4'h0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_nib_out", nib_out, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Basic write then read of address 3.
    write_word(4'h3, 8'hA5);
    read_word(4'h3, 8'hA5);

    // Aborted partial write must leave the old word.
    write_word(4'h4, 8'h5A);
    start(); nib(4'h1); nib(4'h4); nib(4'h7); stop();
    read_word(4'h4, 8'h5A);

    // Write burst wrapping 15 -> 0, read back both ways.
    start(); nib(4'h1); nib(4'hF);
    nib(4'h1); nib(4'h1); nib(4'h2); nib(4'h2);
    stop();
    read_word(4'h0, 8'h22);
    start(); nib(4'h2); nib(4'hF);
    wait_ready();
    exp_q.push_back(4'h1); nib(4'h0);
    exp_q.push_back(4'h1); nib(4'h0);
    wait_ready();
    exp_q.push_back(4'h2); nib(4'h0);
    exp_q.push_back(4'h2); nib(4'h0);
    stop(); tick();

    // Illegal header.
    start(); nib(4'h4);
    chk("err_set", err, 1);
    nib(4'h1); nib(4'h0); nib(4'hF); nib(4'hF);
    chk("err_held", err, 1);
    stop();
    chk("err_clear", err, 0);
    read_word(4'h0, 8'h22);

`ifdef JAR_SRAM_CLEAR_EN
    begin
      int n = 0;
      start(); nib(4'h3);
      while (busy && n < 100) begin
        n++;
        tick();
      end
      chk("clr_busy_cycles", n, 16);
      stop();
      start(); nib(4'h2); nib(4'h0);
      for (int w = 0; w < 16; w++) begin
        wait_ready();
        exp_q.push_back(4'h0); nib(4'h0);
        exp_q.push_back(4'h0); nib(4'h0);
      end
      stop(); tick();
    end
`else
    start(); nib(4'h3);
    chk("clr_illegal_err", err, 1);
    stop();
    chk("clr_illegal_err_clear", err, 0);
    read_word(4'h3, 8'hA5);
`endif

    // Reset in the middle of a read burst.
    write_word(4'h3, 8'hA5);
    start(); nib(4'h2); nib(4'h3);
    wait_ready();
    exp_q.push_back(4'h5); nib(4'h0);
    exp_q.push_back(4'hA); nib(4'h0);
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_nib_out", nib_out, 0);
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    cs = 1'b0; stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    read_word(4'h3, 8'hA5);

    tick(); tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
